// File: rtl/mem.sv
// Memory-access stage: performs MIPS byte/half/word loads and stores over a
// single-outstanding req/ack port and hands results to write-back.
module mem #(
  parameter int unsigned ALU_OPC_WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              result,
  input  logic [31:0]              B,
  input  logic [ALU_OPC_WIDTH-1:0] alu_op,
  input  logic                     mem_inst,
  input  logic [4:0]               dest_reg,
  input  logic                     dest_reg_valid,
  output logic                     stall,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [31:0]              dmem_addr,
  output logic [3:0]               dmem_be,
  output logic [31:0]              dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [31:0]              dmem_rdata,
  output logic                     wb_valid,
  output logic [31:0]              wb_data,
  output logic [4:0]               wb_reg,
  output logic                     wb_reg_valid,
  output logic                     addr_err
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t r_state, w_state_nxt;

  logic        r_req,          w_req_nxt;
  logic        r_we,           w_we_nxt;
  logic [31:0] r_addr,         w_addr_nxt;
  logic [3:0]  r_be,           w_be_nxt;
  logic [31:0] r_wdata,        w_wdata_nxt;
  logic        r_wb_valid,     w_wb_valid_nxt;
  logic [31:0] r_wb_data,      w_wb_data_nxt;
  logic [4:0]  r_wb_reg,       w_wb_reg_nxt;
  logic        r_wb_reg_valid, w_wb_reg_valid_nxt;
  logic        r_addr_err,     w_addr_err_nxt;
  logic [5:0]  r_op,           w_op_nxt;
  logic [1:0]  r_lane,         w_lane_nxt;
  logic [4:0]  r_dest,         w_dest_nxt;
  logic        r_dest_valid,   w_dest_valid_nxt;
  logic [31:0] r_ea,           w_ea_nxt;

  logic [5:0]  w_opc;
  logic        w_is_load, w_is_store;
  logic        w_sz_byte, w_sz_half, w_sz_word;
  logic        w_misaligned;
  logic [3:0]  w_be_req;
  logic [31:0] w_wdata_req;
  logic        w_r_is_load;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load_data;
  logic        w_unused_opc;

  assign w_opc        = alu_op[11:6];
  assign w_unused_opc = ^alu_op[5:0];

  // Decode of the incoming instruction
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_sz_byte  = 1'b0;
    w_sz_half  = 1'b0;
    w_sz_word  = 1'b0;
    case (w_opc)
      OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_sz_byte = 1'b1; end
      OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_sz_half = 1'b1; end
      OP_LW:         begin w_is_load  = 1'b1; w_sz_word = 1'b1; end
      OP_SB:         begin w_is_store = 1'b1; w_sz_byte = 1'b1; end
      OP_SH:         begin w_is_store = 1'b1; w_sz_half = 1'b1; end
      OP_SW:         begin w_is_store = 1'b1; w_sz_word = 1'b1; end
      default:       ;
    endcase
  end

  assign w_misaligned = (w_sz_half & result[0]) | (w_sz_word & (|result[1:0]));

  always_comb begin
    w_be_req    = '0;
    w_wdata_req = B;
    if (w_sz_byte) begin
      w_be_req    = 4'b0001 << result[1:0];
      w_wdata_req = {4{B[7:0]}};
    end else if (w_sz_half) begin
      w_be_req    = result[1] ? 4'b1100 : 4'b0011;
      w_wdata_req = {2{B[15:0]}};
    end else if (w_sz_word) begin
      w_be_req    = 4'b1111;
    end
  end

  // Load extraction uses the lane and opcode captured at accept time
  assign w_r_is_load = (r_op == OP_LB) || (r_op == OP_LBU) || (r_op == OP_LH) ||
                       (r_op == OP_LHU) || (r_op == OP_LW);

  always_comb begin
    w_ld_byte = dmem_rdata[7:0];
    case (r_lane)
      2'd0:    w_ld_byte = dmem_rdata[7:0];
      2'd1:    w_ld_byte = dmem_rdata[15:8];
      2'd2:    w_ld_byte = dmem_rdata[23:16];
      default: w_ld_byte = dmem_rdata[31:24];
    endcase
  end

  assign w_ld_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_load_data = dmem_rdata;
    case (r_op)
      OP_LB:   w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      OP_LBU:  w_load_data = {24'h0, w_ld_byte};
      OP_LH:   w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
      OP_LHU:  w_load_data = {16'h0, w_ld_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_req_nxt          = r_req;
    w_we_nxt           = r_we;
    w_addr_nxt         = r_addr;
    w_be_nxt           = r_be;
    w_wdata_nxt        = r_wdata;
    w_wb_valid_nxt     = 1'b0;
    w_wb_data_nxt      = r_wb_data;
    w_wb_reg_nxt       = r_wb_reg;
    w_wb_reg_valid_nxt = 1'b0;
    w_addr_err_nxt     = 1'b0;
    w_op_nxt           = r_op;
    w_lane_nxt         = r_lane;
    w_dest_nxt         = r_dest;
    w_dest_valid_nxt   = r_dest_valid;
    w_ea_nxt           = r_ea;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (!mem_inst) begin
            w_wb_valid_nxt     = 1'b1;
            w_wb_data_nxt      = result;
            w_wb_reg_nxt       = dest_reg;
            w_wb_reg_valid_nxt = dest_reg_valid;
          end else if (!(w_is_load || w_is_store)) begin
            w_wb_valid_nxt     = 1'b1;
            w_wb_data_nxt      = result;
            w_wb_reg_nxt       = dest_reg;
          end else if (w_misaligned) begin
            w_wb_valid_nxt     = 1'b1;
            w_addr_err_nxt     = 1'b1;
            w_wb_data_nxt      = result;
            w_wb_reg_nxt       = dest_reg;
          end else begin
            w_state_nxt        = S_ACCESS;
            w_req_nxt          = 1'b1;
            w_we_nxt           = w_is_store;
            w_addr_nxt         = {result[31:2], 2'b00};
            w_be_nxt           = w_be_req;
            w_wdata_nxt        = w_wdata_req;
            w_op_nxt           = w_opc;
            w_lane_nxt         = result[1:0];
            w_dest_nxt         = dest_reg;
            w_dest_valid_nxt   = dest_reg_valid;
            w_ea_nxt           = result;
          end
        end
      end
      S_ACCESS: begin
        if (dmem_ack) begin
          w_state_nxt        = S_IDLE;
          w_req_nxt          = 1'b0;
          w_we_nxt           = 1'b0;
          w_wb_valid_nxt     = 1'b1;
          w_wb_reg_nxt       = r_dest;
          w_wb_reg_valid_nxt = w_r_is_load & r_dest_valid;
          w_wb_data_nxt      = w_r_is_load ? w_load_data : r_ea;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_reg       <= '0;
      r_wb_reg_valid <= 1'b0;
      r_addr_err     <= 1'b0;
      r_op           <= '0;
      r_lane         <= '0;
      r_dest         <= '0;
      r_dest_valid   <= 1'b0;
      r_ea           <= '0;
    end else begin
      r_req          <= w_req_nxt;
      r_we           <= w_we_nxt;
      r_addr         <= w_addr_nxt;
      r_be           <= w_be_nxt;
      r_wdata        <= w_wdata_nxt;
      r_wb_valid     <= w_wb_valid_nxt;
      r_wb_data      <= w_wb_data_nxt;
      r_wb_reg       <= w_wb_reg_nxt;
      r_wb_reg_valid <= w_wb_reg_valid_nxt;
      r_addr_err     <= w_addr_err_nxt;
      r_op           <= w_op_nxt;
      r_lane         <= w_lane_nxt;
      r_dest         <= w_dest_nxt;
      r_dest_valid   <= w_dest_valid_nxt;
      r_ea           <= w_ea_nxt;
    end
  end

  assign stall        = (r_state == S_ACCESS);
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_be      = r_be;
  assign dmem_wdata   = r_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_reg       = r_wb_reg;
  assign wb_reg_valid = r_wb_reg_valid;
  assign addr_err     = r_addr_err;

  a_err_with_wb: assert property (@(posedge clock) disable iff (reset) r_addr_err |-> r_wb_valid);
  a_req_aligned: assert property (@(posedge clock) disable iff (reset) r_req |-> (r_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_mem.sv
// Randomized self-checking bench for mem against a behavioural model of
// MIPS load/store lane selection, extension and request timing.
module tb_mem;

  logic        clock = 1'b0;
  logic        reset, in_valid, mem_inst, dest_reg_valid, dmem_ack;
  logic [31:0] result, B, dmem_rdata;
  logic [11:0] alu_op;
  logic [4:0]  dest_reg;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_valid, addr_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_reg;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem #(.ALU_OPC_WIDTH(12)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .result(result), .B(B),
    .alu_op(alu_op), .mem_inst(mem_inst), .dest_reg(dest_reg),
    .dest_reg_valid(dest_reg_valid), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_reg_valid(wb_reg_valid), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  // Observations of one instruction, filled in by run_inst
  int unsigned ob_req_cyc, ob_stall_cyc, ob_lat;
  logic [31:0] ob_addr, ob_wdata, ob_wbd;
  logic [3:0]  ob_be;
  logic [4:0]  ob_wbr;
  logic        ob_we, ob_stable, ob_wb_seen, ob_err, ob_wbrv, ob_extra, ob_err_alone;

  function automatic int unsigned op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2b:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] rd);
    int unsigned k;
    longint v;
    k = a % 4;
    v = rd;
    case (op)
      6'h20: begin v = (rd >> (8 * k)) % 256;  if (v >= 128) v = v - 256; end
      6'h24: v = (rd >> (8 * k)) % 256;
      6'h21: begin v = (rd >> (16 * (k / 2))) % 65536; if (v >= 32768) v = v - 65536; end
      6'h25: v = (rd >> (16 * (k / 2))) % 65536;
      default: v = rd;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] a);
    int unsigned k;
    k = a % 4;
    case (op_size(op))
      1: return 4'(1 << k);
      2: return 4'(3 << (2 * (k / 2)));
      4: return 4'hf;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] b);
    case (op_size(op))
      1: return (b % 256) * 32'h0101_0101;
      2: return (b % 65536) * 32'h0001_0001;
      default: return b;
    endcase
  endfunction

  // Drive one instruction from IDLE and record what the DUT does until wb_valid.
  task automatic run_inst(input logic [5:0] op, input logic mi, input logic [31:0] res,
                          input logic [31:0] b, input logic [4:0] dr, input logic drv,
                          input int unsigned waits, input logic [31:0] rd);
    int unsigned cyc;
    ob_req_cyc = 0; ob_stall_cyc = 0; ob_lat = 0; ob_addr = '0; ob_wdata = '0;
    ob_wbd = '0; ob_be = '0; ob_wbr = '0; ob_we = 1'b0; ob_stable = 1'b1;
    ob_wb_seen = 1'b0; ob_err = 1'b0; ob_wbrv = 1'b0; ob_extra = 1'b0; ob_err_alone = 1'b0;
    in_valid = 1'b1; mem_inst = mi; result = res; B = b; dest_reg = dr; dest_reg_valid = drv;
    alu_op = {op, 6'($urandom_range(0, 63))};
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; result = $urandom; B = $urandom; dest_reg = 5'($urandom);
    alu_op = 12'($urandom); dest_reg_valid = 1'($urandom);
    cyc = 0;
    while (!ob_wb_seen && cyc < 64) begin
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (addr_err && !wb_valid) ob_err_alone = 1'b1;
      if (stall) ob_stall_cyc++;
      if (wb_valid) begin
        ob_wb_seen = 1'b1; ob_wbd = wb_data; ob_wbr = wb_reg; ob_wbrv = wb_reg_valid;
        ob_err = addr_err; ob_lat = cyc + 1;
      end else if (dmem_req) begin
        if (ob_req_cyc == 0) begin
          ob_addr = dmem_addr; ob_be = dmem_be; ob_we = dmem_we; ob_wdata = dmem_wdata;
        end else if (dmem_addr !== ob_addr || dmem_be !== ob_be || dmem_we !== ob_we ||
                     dmem_wdata !== ob_wdata) begin
          ob_stable = 1'b0;
        end
        if (ob_req_cyc == waits) begin
          dmem_ack = 1'b1; dmem_rdata = rd;
        end
        ob_req_cyc++;
      end
      if (!ob_wb_seen) begin
        @(negedge clock);
        cyc++;
      end
    end
    dmem_ack = 1'b0;
    if (ob_wb_seen) begin
      @(negedge clock);
      ob_extra = wb_valid;
      if (addr_err && !wb_valid) ob_err_alone = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if ({stall, dmem_req, dmem_we, wb_valid, wb_reg_valid, addr_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000",
                         {stall, dmem_req, dmem_we, wb_valid, wb_reg_valid, addr_err}); end
    checks++; if ({dmem_addr, dmem_be, dmem_wdata, wb_data, wb_reg} !== 105'b0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h/%h want all zero",
                         dmem_addr, dmem_be, dmem_wdata, wb_data, wb_reg); end
    reset = 1'b0;
  endtask

  task automatic test_alu_passthrough;
    run_inst(6'h00, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    checks++; if (ob_wb_seen !== 1'b1 || ob_lat != 1) begin
      errors++; $display("FAIL alu_latency: got seen=%b lat=%0d want seen=1 lat=1", ob_wb_seen, ob_lat); end
    checks++; if (ob_wbd !== 32'h1234 || ob_wbr !== 5'd5 || ob_wbrv !== 1'b1) begin
      errors++; $display("FAIL alu_wb: got %h r%0d v%b want 00001234 r5 v1", ob_wbd, ob_wbr, ob_wbrv); end
    checks++; if (ob_stall_cyc != 0 || ob_req_cyc != 0 || ob_extra !== 1'b0) begin
      errors++; $display("FAIL alu_nostall: got stall=%0d req=%0d extra=%b want 0 0 0",
                         ob_stall_cyc, ob_req_cyc, ob_extra); end
  endtask

  task automatic test_lb_sign;
    run_inst(6'h20, 1'b1, 32'h0000_0103, 32'h0, 5'd3, 1'b1, 0, 32'h80FF_0000);
    checks++; if (ob_addr !== 32'h100 || ob_be !== 4'b1000 || ob_we !== 1'b0) begin
      errors++; $display("FAIL lb_req: got %h be=%b we=%b want 00000100 be=1000 we=0", ob_addr, ob_be, ob_we); end
    checks++; if (ob_wbd !== 32'hFFFF_FF80 || ob_wbrv !== 1'b1 || ob_lat != 2) begin
      errors++; $display("FAIL lb_data: got %h v%b lat=%0d want ffffff80 v1 lat=2", ob_wbd, ob_wbrv, ob_lat); end
    checks++; if (ob_stall_cyc != 1 || ob_req_cyc != 1) begin
      errors++; $display("FAIL lb_stall: got stall=%0d req=%0d want 1 1", ob_stall_cyc, ob_req_cyc); end
    run_inst(6'h24, 1'b1, 32'h0000_0103, 32'h0, 5'd3, 1'b1, 0, 32'h80FF_0000);
    checks++; if (ob_wbd !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_data: got %h want 00000080", ob_wbd); end
  endtask

  task automatic test_sh_wait;
    run_inst(6'h29, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd8, 1'b1, 3, 32'h0);
    checks++; if (ob_we !== 1'b1 || ob_be !== 4'b1100 || ob_wdata !== 32'hBEEF_BEEF || ob_addr !== 32'h200) begin
      errors++; $display("FAIL sh_req: got we=%b be=%b wd=%h a=%h want 1 1100 beefbeef 00000200",
                         ob_we, ob_be, ob_wdata, ob_addr); end
    checks++; if (ob_req_cyc != 4 || ob_stall_cyc != 4 || ob_stable !== 1'b1) begin
      errors++; $display("FAIL sh_hold: got req=%0d stall=%0d stable=%b want 4 4 1",
                         ob_req_cyc, ob_stall_cyc, ob_stable); end
    checks++; if (ob_wb_seen !== 1'b1 || ob_wbrv !== 1'b0 || ob_extra !== 1'b0) begin
      errors++; $display("FAIL sh_wb: got seen=%b v=%b extra=%b want 1 0 0", ob_wb_seen, ob_wbrv, ob_extra); end
  endtask

  task automatic test_misaligned;
    run_inst(6'h23, 1'b1, 32'h0000_0301, 32'h0, 5'd4, 1'b1, 0, 32'h0);
    checks++; if (ob_req_cyc != 0 || ob_stall_cyc != 0) begin
      errors++; $display("FAIL mis_noreq: got req=%0d stall=%0d want 0 0", ob_req_cyc, ob_stall_cyc); end
    checks++; if (ob_lat != 1 || ob_err !== 1'b1 || ob_wbrv !== 1'b0 || ob_wbd !== 32'h301) begin
      errors++; $display("FAIL mis_wb: got lat=%0d err=%b v=%b d=%h want 1 1 0 00000301",
                         ob_lat, ob_err, ob_wbrv, ob_wbd); end
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1; mem_inst = 1'b1; alu_op = {6'h23, 6'h0}; result = 32'h400;
    dest_reg = 5'd7; dest_reg_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    checks++; if (stall !== 1'b1 || dmem_req !== 1'b1) begin
      errors++; $display("FAIL b2b_access: got stall=%b req=%b want 1 1", stall, dmem_req); end
    mem_inst = 1'b0; alu_op = 12'h021; result = 32'hABCD_0001; dest_reg = 5'd9;
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
    @(posedge clock); @(negedge clock);
    dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h1122_3344 || wb_reg !== 5'd7 || stall !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got v=%b d=%h r=%0d stall=%b want 1 11223344 7 0",
                         wb_valid, wb_data, wb_reg, stall); end
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hABCD_0001 || wb_reg !== 5'd9) begin
      errors++; $display("FAIL b2b_second: got v=%b d=%h r=%0d want 1 abcd0001 9", wb_valid, wb_data, wb_reg); end
    @(posedge clock); @(negedge clock);
    checks++; if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drop: got wb_valid=%b want 0", wb_valid); end
  endtask

  task automatic test_reset_mid_access;
    in_valid = 1'b1; mem_inst = 1'b1; alu_op = {6'h23, 6'h0}; result = 32'h500;
    dest_reg = 5'd2; dest_reg_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    checks++; if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_req: got %b want 1", dmem_req); end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0 || wb_reg_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear: got req=%b wb=%b stall=%b rv=%b want 0 0 0 0",
                         dmem_req, wb_valid, stall, wb_reg_valid); end
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clock); @(negedge clock);
    dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_late_ack: got wb=%b req=%b stall=%b want 0 0 0", wb_valid, dmem_req, stall); end
    run_inst(6'h23, 1'b1, 32'h0000_0504, 32'h0, 5'd6, 1'b1, 1, 32'hCAFE_F00D);
    checks++; if (ob_wb_seen !== 1'b1 || ob_wbd !== 32'hCAFE_F00D || ob_wbr !== 5'd6 || ob_lat != 3) begin
      errors++; $display("FAIL rst_next_lw: got seen=%b d=%h r=%0d lat=%0d want 1 cafef00d 6 3",
                         ob_wb_seen, ob_wbd, ob_wbr, ob_lat); end
  endtask

  task automatic test_random;
    logic [5:0]  ops [10];
    logic [5:0]  op;
    logic [31:0] res, b, rd;
    logic [4:0]  dr;
    logic        mi, drv, misal, exp_rv;
    int unsigned waits, sz;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h00, 6'h0f};
    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 9)];
      mi = ($urandom_range(0, 7) != 0);
      res = $urandom; b = $urandom; rd = $urandom; dr = 5'($urandom); drv = 1'($urandom);
      if ($urandom_range(0, 1) == 0) res = res - (res % 4);
      waits = $urandom_range(0, 3);
      run_inst(op, mi, res, b, dr, drv, waits, rd);
      sz = op_size(op);
      misal = mi && sz != 0 && (res % sz) != 0;
      checks++; if (ob_wb_seen !== 1'b1 || ob_wbr !== dr || ob_extra !== 1'b0 || ob_err_alone !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_retire: got seen=%b r=%0d extra=%b lone=%b want 1 %0d 0 0",
                           i, ob_wb_seen, ob_wbr, ob_extra, ob_err_alone, dr); end
      checks++; if (ob_err !== misal) begin
        errors++; $display("FAIL rnd%0d_err: got %b want %b (op %h a %h)", i, ob_err, misal, op, res); end
      if (!mi || sz == 0 || misal) begin
        exp_rv = !mi ? drv : 1'b0;
        checks++; if (ob_req_cyc != 0 || ob_lat != 1 || ob_wbrv !== exp_rv) begin
          errors++; $display("FAIL rnd%0d_noreq: got req=%0d lat=%0d v=%b want 0 1 %b",
                             i, ob_req_cyc, ob_lat, ob_wbrv, exp_rv); end
        if (!mi || misal) begin
          checks++; if (ob_wbd !== res) begin
            errors++; $display("FAIL rnd%0d_pass: got %h want %h", i, ob_wbd, res); end
        end
      end else begin
        checks++; if (ob_req_cyc != waits + 1 || ob_stall_cyc != waits + 1 || ob_stable !== 1'b1 ||
                      ob_lat != waits + 2) begin
          errors++; $display("FAIL rnd%0d_timing: got req=%0d stall=%0d stable=%b lat=%0d want %0d %0d 1 %0d",
                             i, ob_req_cyc, ob_stall_cyc, ob_stable, ob_lat, waits + 1, waits + 1, waits + 2); end
        checks++; if (ob_addr !== res - (res % 4) || ob_be !== model_be(op, res) || ob_we !== !op_load(op)) begin
          errors++; $display("FAIL rnd%0d_req: got a=%h be=%b we=%b want %h %b %b", i, ob_addr, ob_be,
                             ob_we, res - (res % 4), model_be(op, res), !op_load(op)); end
        if (op_load(op)) begin
          checks++; if (ob_wbd !== model_load(op, res, rd) || ob_wbrv !== drv) begin
            errors++; $display("FAIL rnd%0d_load: got %h v=%b want %h v=%b (op %h a %h rd %h)",
                               i, ob_wbd, ob_wbrv, model_load(op, res, rd), drv, op, res, rd); end
        end else begin
          checks++; if (ob_wdata !== model_wdata(op, b) || ob_wbrv !== 1'b0) begin
            errors++; $display("FAIL rnd%0d_store: got wd=%h v=%b want %h v=0",
                               i, ob_wdata, ob_wbrv, model_wdata(op, b)); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_inst = 1'b0; dest_reg_valid = 1'b0; dmem_ack = 1'b0;
    result = '0; B = '0; dmem_rdata = '0; alu_op = '0; dest_reg = '0;
    test_reset();
    test_alu_passthrough();
    test_lb_sign();
    test_sh_wait();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
